fetch_predict_ctrl: RTL and testbench

//  Fetch-stage next-PC controller that consumes the BTB's lookup result (hit/BTA).

---
 rtl/fetch_predict_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_predict_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict_ctrl.sv
// Fetch next-PC controller: gates BTB hits with a 2-bit BHT, carries predictions F->D->E, resolves in E.
// Zero-bubble correct taken redirect, two-bubble mispredict; stalls hold F/D and bubble E, flush beats stall.
module fetch_predict_ctrl #(
    parameter int          W_PC     = 8,
    parameter int          N_BHT    = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            btb_hit,
    input  logic [31:0]     btb_bta,
    input  logic            branchE,
    input  logic            branchTakenE,
    input  logic [31:0]     aluBranchAddress,
    output logic [31:0]     pcF,
    output logic [W_PC-1:0] btb_pc,
    output logic            predictTakenF,
    output logic            branchPredictedE,
    output logic [31:0]     pcOfAluBranchAddress,
    output logic            mispredictE,
    output logic            flushD,
    output logic            flushE,
    output logic [15:0]     mispredictCount
);
    localparam int IW = $clog2(N_BHT);

    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic          pred;
        logic [31:0]   predBta;
        logic [IW-1:0] bhtIdx;
    } stage_t;

    stage_t        regD;
    stage_t        regE;
    logic [1:0]    bht [N_BHT];
    logic [IW-1:0] idxF;
    logic [31:0]   pcPlus4E;
    logic [31:0]   recoveryPc;
    logic [31:0]   pcNext;
    logic          wrongTarget;

    assign idxF          = pcF[IW+1:2];
    assign btb_pc        = pcF[W_PC-1:0];
    assign predictTakenF = btb_hit & bht[idxF][1];

    assign pcPlus4E             = regE.pc + 32'd4;
    assign pcOfAluBranchAddress = pcPlus4E;
    assign branchPredictedE     = regE.valid & regE.pred;

    // A predicted-taken branch that goes elsewhere is as wrong as a direction miss.
    assign wrongTarget = branchTakenE & regE.pred & (regE.predBta != aluBranchAddress);
    assign mispredictE = regE.valid & branchE & ((branchTakenE != regE.pred) | wrongTarget);
    assign flushD      = mispredictE;
    assign flushE      = mispredictE;
    assign recoveryPc  = branchTakenE ? aluBranchAddress : pcPlus4E;

    always_comb begin
        pcNext = pcF + 32'd4;
        if (mispredictE) begin
            pcNext = recoveryPc;
        end else if (stallF) begin
            pcNext = pcF;
        end else if (predictTakenF) begin
            pcNext = btb_bta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcF             <= RESET_PC;
            regD            <= '0;
            regE            <= '0;
            mispredictCount <= 16'd0;
            for (int i = 0; i < N_BHT; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            pcF <= pcNext;

            if (flushD) begin
                regD.valid <= 1'b0;
            end else if (!stallD) begin
                regD <= '{valid: 1'b1, pc: pcF, pred: predictTakenF, predBta: btb_bta, bhtIdx: idxF};
            end

            if (flushE || stallD) begin
                regE.valid <= 1'b0;
            end else begin
                regE <= regD;
            end

            if (mispredictE && mispredictCount != 16'hFFFF) begin
                mispredictCount <= mispredictCount + 16'd1;
            end

            // Same-cycle F reads of this index see the old counter value.
            if (regE.valid && branchE) begin
                if (branchTakenE) begin
                    if (bht[regE.bhtIdx] != 2'b11) begin
                        bht[regE.bhtIdx] <= bht[regE.bhtIdx] + 2'b01;
                    end
                end else if (bht[regE.bhtIdx] != 2'b00) begin
                    bht[regE.bhtIdx] <= bht[regE.bhtIdx] - 2'b01;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_predict_ctrl.sv
// Directed bench for fetch_predict_ctrl: BTB and execute unit are driven by hand-sequenced vectors.
module tb_fetch_predict_ctrl;
    logic        clk;
    logic        reset;
    logic        stallF;
    logic        stallD;
    logic        btb_hit;
    logic [31:0] btb_bta;
    logic        branchE;
    logic        branchTakenE;
    logic [31:0] aluBranchAddress;
    logic [31:0] pcF;
    logic [7:0]  btb_pc;
    logic        predictTakenF;
    logic        branchPredictedE;
    logic [31:0] pcOfAluBranchAddress;
    logic        mispredictE;
    logic        flushD;
    logic        flushE;
    logic [15:0] mispredictCount;

    int total = 0;
    int bad   = 0;

    fetch_predict_ctrl #(.W_PC(8), .N_BHT(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD),
        .btb_hit(btb_hit), .btb_bta(btb_bta), .branchE(branchE),
        .branchTakenE(branchTakenE), .aluBranchAddress(aluBranchAddress),
        .pcF(pcF), .btb_pc(btb_pc), .predictTakenF(predictTakenF),
        .branchPredictedE(branchPredictedE), .pcOfAluBranchAddress(pcOfAluBranchAddress),
        .mispredictE(mispredictE), .flushD(flushD), .flushE(flushE),
        .mispredictCount(mispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] target);
        branchE = 1'b1;
        branchTakenE = taken;
        aluBranchAddress = target;
        #1;
    endtask

    task automatic idle();
        branchE = 1'b0;
        branchTakenE = 1'b0;
        aluBranchAddress = 32'h0;
        btb_hit = 1'b0;
        btb_bta = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stallF = 1'b0; stallD = 1'b0;
        idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (pcF !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pcF, 32'h0); end
        total++; if (flushD !== 1'b0) begin bad++; $display("FAIL reset_flushD got=%b want=0", flushD); end
        total++; if (mispredictCount !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", mispredictCount); end
        total++; if (branchPredictedE !== 1'b0) begin bad++; $display("FAIL reset_predE got=%b want=0", branchPredictedE); end
        tick();
        total++; if (pcF !== 32'h4) begin bad++; $display("FAIL seq_pc4 got=%h want=%h", pcF, 32'h4); end
        tick();
        total++; if (pcF !== 32'h8) begin bad++; $display("FAIL seq_pc8 got=%h want=%h", pcF, 32'h8); end
        tick();
        total++; if (pcF !== 32'hC) begin bad++; $display("FAIL seq_pc12 got=%h want=%h", pcF, 32'hC); end
        total++; if (flushD !== 1'b0) begin bad++; $display("FAIL seq_flushD got=%b want=0", flushD); end
    endtask

    task automatic test_weak_hit();
        tick();
        btb_hit = 1'b1; btb_bta = 32'h40;
        #1;
        total++; if (btb_pc !== 8'h10) begin bad++; $display("FAIL weak_btbpc got=%h want=10", btb_pc); end
        total++; if (predictTakenF !== 1'b0) begin bad++; $display("FAIL weak_pred got=%b want=0", predictTakenF); end
        tick();
        idle();
        total++; if (pcF !== 32'h14) begin bad++; $display("FAIL weak_next got=%h want=%h", pcF, 32'h14); end
    endtask

    task automatic test_taken_unpredicted();
        tick();
        resolve(1'b1, 32'h80);
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL tu_mispredict got=%b want=1", mispredictE); end
        total++; if ({flushD, flushE} !== 2'b11) begin bad++; $display("FAIL tu_flush got=%b want=11", {flushD, flushE}); end
        total++; if (pcOfAluBranchAddress !== 32'h14) begin bad++; $display("FAIL tu_pcplus4 got=%h want=%h", pcOfAluBranchAddress, 32'h14); end
        total++; if (branchPredictedE !== 1'b0) begin bad++; $display("FAIL tu_predE got=%b want=0", branchPredictedE); end
        tick();
        idle();
        total++; if (pcF !== 32'h80) begin bad++; $display("FAIL tu_redirect got=%h want=%h", pcF, 32'h80); end
        total++; if (mispredictCount !== 16'd1) begin bad++; $display("FAIL tu_count got=%0d want=1", mispredictCount); end
        // Flushed D then E: the next two E slots must not resolve.
        branchE = 1'b1; branchTakenE = 1'b1; aluBranchAddress = 32'h999;
        #1;
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL tu_bubble1 got=%b want=0", mispredictE); end
        tick();
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL tu_bubble2 got=%b want=0", mispredictE); end
        idle();
        tick();
        // Instruction at 0x80 is in E: call it a taken branch back to 0x10.
        resolve(1'b1, 32'h10);
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL back_mispredict got=%b want=1", mispredictE); end
        tick();
        idle();
        total++; if (pcF !== 32'h10) begin bad++; $display("FAIL back_pc got=%h want=%h", pcF, 32'h10); end
        total++; if (mispredictCount !== 16'd2) begin bad++; $display("FAIL back_count got=%0d want=2", mispredictCount); end
    endtask

    task automatic test_trained_hit();
        total++; if (predictTakenF !== 1'b0) begin bad++; $display("FAIL miss_no_pred got=%b want=0", predictTakenF); end
        btb_hit = 1'b1; btb_bta = 32'h80;
        #1;
        total++; if (predictTakenF !== 1'b1) begin bad++; $display("FAIL trained_pred got=%b want=1", predictTakenF); end
        tick();
        idle();
        total++; if (pcF !== 32'h80) begin bad++; $display("FAIL trained_next got=%h want=%h", pcF, 32'h80); end
        tick();
        total++; if (branchPredictedE !== 1'b1) begin bad++; $display("FAIL trained_predE got=%b want=1", branchPredictedE); end
        resolve(1'b1, 32'h80);
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL trained_nomis got=%b want=0", mispredictE); end
        total++; if (flushD !== 1'b0) begin bad++; $display("FAIL trained_noflush got=%b want=0", flushD); end
        tick();
        idle();
        total++; if (pcF !== 32'h88) begin bad++; $display("FAIL trained_flow got=%h want=%h", pcF, 32'h88); end
        total++; if (mispredictCount !== 16'd2) begin bad++; $display("FAIL trained_count got=%0d want=2", mispredictCount); end
        // 0x80 now in E, fetched without prediction: redirect to 0x10 again.
        resolve(1'b1, 32'h10);
        tick();
        idle();
        total++; if (pcF !== 32'h10) begin bad++; $display("FAIL back2_pc got=%h want=%h", pcF, 32'h10); end
        total++; if (mispredictCount !== 16'd3) begin bad++; $display("FAIL back2_count got=%0d want=3", mispredictCount); end
    endtask

    task automatic test_predicted_not_taken();
        btb_hit = 1'b1; btb_bta = 32'h80;
        #1;
        total++; if (predictTakenF !== 1'b1) begin bad++; $display("FAIL pnt_pred got=%b want=1", predictTakenF); end
        tick();
        idle();
        tick();
        resolve(1'b0, 32'h80);
        total++; if (branchPredictedE !== 1'b1) begin bad++; $display("FAIL pnt_predE got=%b want=1", branchPredictedE); end
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL pnt_mispredict got=%b want=1", mispredictE); end
        total++; if (pcOfAluBranchAddress !== 32'h14) begin bad++; $display("FAIL pnt_pcplus4 got=%h want=%h", pcOfAluBranchAddress, 32'h14); end
        tick();
        idle();
        total++; if (pcF !== 32'h14) begin bad++; $display("FAIL pnt_recover got=%h want=%h", pcF, 32'h14); end
        total++; if (mispredictCount !== 16'd4) begin bad++; $display("FAIL pnt_count got=%0d want=4", mispredictCount); end
    endtask

    task automatic test_stall_flush();
        tick(); tick();
        total++; if (pcF !== 32'h1C) begin bad++; $display("FAIL stall_pre got=%h want=%h", pcF, 32'h1C); end
        stallF = 1'b1; stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pcF !== 32'h1C) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, pcF, 32'h1C); end
            branchE = 1'b1; branchTakenE = 1'b1; aluBranchAddress = 32'h200;
            #1;
            total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL stall_bubble%0d got=%b want=0", i, mispredictE); end
            idle();
        end
        stallF = 1'b0; stallD = 1'b0;
        tick();
        total++; if (pcF !== 32'h20) begin bad++; $display("FAIL stall_release got=%h want=%h", pcF, 32'h20); end
        total++; if (pcOfAluBranchAddress !== 32'h1C) begin bad++; $display("FAIL stall_dheld got=%h want=%h", pcOfAluBranchAddress, 32'h1C); end
        stallF = 1'b1; stallD = 1'b1;
        resolve(1'b1, 32'h100);
        total++; if (mispredictE !== 1'b1) begin bad++; $display("FAIL sflush_mis got=%b want=1", mispredictE); end
        tick();
        idle();
        total++; if (pcF !== 32'h100) begin bad++; $display("FAIL sflush_pc got=%h want=%h", pcF, 32'h100); end
        total++; if (mispredictCount !== 16'd5) begin bad++; $display("FAIL sflush_count got=%0d want=5", mispredictCount); end
        stallF = 1'b0; stallD = 1'b0;
        tick();
        branchE = 1'b1; branchTakenE = 1'b1; aluBranchAddress = 32'h300;
        #1;
        total++; if (mispredictE !== 1'b0) begin bad++; $display("FAIL sflush_dkilled got=%b want=0", mispredictE); end
        idle();
        total++; if (pcF !== 32'h104) begin bad++; $display("FAIL sflush_next got=%h want=%h", pcF, 32'h104); end
    endtask

    task automatic test_reset_mid_stall();
        stallF = 1'b1; stallD = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; stallF = 1'b0; stallD = 1'b0;
        #1;
        total++; if (pcF !== 32'h0) begin bad++; $display("FAIL rst2_pc got=%h want=%h", pcF, 32'h0); end
        total++; if (mispredictCount !== 16'd0) begin bad++; $display("FAIL rst2_count got=%0d want=0", mispredictCount); end
        tick(); tick(); tick(); tick();
        btb_hit = 1'b1; btb_bta = 32'h80;
        #1;
        total++; if (pcF !== 32'h10) begin bad++; $display("FAIL rst2_seq got=%h want=%h", pcF, 32'h10); end
        total++; if (predictTakenF !== 1'b0) begin bad++; $display("FAIL rst2_bht got=%b want=0", predictTakenF); end
        idle();
    endtask

    initial begin
        test_reset();
        test_weak_hit();
        test_taken_unpredicted();
        test_trained_hit();
        test_predicted_not_taken();
        test_stall_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
